// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median image sequencer.
//   state_t    : sequencer states
//   win_ofs_t  : (dy, dx) neighbour offset of one window beat
//   win_ofs()  : offset table for k = 0..8, row-major from (-1,-1) to (+1,+1)
package median_pkg;

    localparam int unsigned WIN_N       = 9;
    localparam int unsigned K_W         = 4;
    localparam int unsigned CENTRE_K    = 4;
    localparam int unsigned TMO_DEFAULT = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY_RD,
        ST_COPY_WR,
        ST_FETCH,
        ST_WAIT_MED,
        ST_WRITE,
        ST_NEXT,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        OFS_M1,
        OFS_0,
        OFS_P1
    } ofs_t;

    typedef struct packed {
        ofs_t dy;
        ofs_t dx;
    } win_ofs_t;

    // Neighbour offset for window beat k.
    function automatic win_ofs_t win_ofs(input logic [K_W-1:0] k);
        win_ofs_t o;
        o = '{dy: OFS_0, dx: OFS_0};
        case (k)
            K_W'(0): o = '{dy: OFS_M1, dx: OFS_M1};
            K_W'(1): o = '{dy: OFS_M1, dx: OFS_0 };
            K_W'(2): o = '{dy: OFS_M1, dx: OFS_P1};
            K_W'(3): o = '{dy: OFS_0,  dx: OFS_M1};
            K_W'(4): o = '{dy: OFS_0,  dx: OFS_0 };
            K_W'(5): o = '{dy: OFS_0,  dx: OFS_P1};
            K_W'(6): o = '{dy: OFS_P1, dx: OFS_M1};
            K_W'(7): o = '{dy: OFS_P1, dx: OFS_0 };
            K_W'(8): o = '{dy: OFS_P1, dx: OFS_P1};
            default: o = '{dy: OFS_0,  dx: OFS_0 };
        endcase
        return o;
    endfunction

endpackage

// File: rtl/median_win_addr.sv
// Window address generator: base pixel address plus the (dy, dx) offset of beat k,
// built from +/-IMG_W and +/-1 only.
//   base   : address of the window centre pixel
//   k      : window beat index 0..8
//   addr_c : combinational address of the neighbour pixel
module median_win_addr
    import median_pkg::*;
#(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [K_W-1:0]    k,
    output logic [ADDR_W-1:0] addr_c
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    win_ofs_t              ofs;
    logic     [ADDR_W-1:0] row_addr;

    // Row step first, then column step.
    always_comb begin
        ofs      = win_ofs(k);
        row_addr = base;
        case (ofs.dy)
            OFS_M1:  row_addr = base - ROW_STEP;
            OFS_P1:  row_addr = base + ROW_STEP;
            default: row_addr = base;
        endcase
        addr_c = row_addr;
        case (ofs.dx)
            OFS_M1:  addr_c = row_addr - ADDR_W'(1);
            OFS_P1:  addr_c = row_addr + ADDR_W'(1);
            default: addr_c = row_addr;
        endcase
    end

endmodule

// File: rtl/median_img_ctrl.sv
// Frame sequencer for the 3x3 median filter. Scans the image in raster order,
// copies border pixels straight through and streams each interior 3x3 window
// to the median core, writing its result (or the centre pixel on timeout).
//   CLK, nRST        : clock, async active-low reset
//   START/BUSY/DONE  : frame start pulse, busy level, end-of-frame pulse
//   ERR              : sticky median timeout flag
//   RADDR/RDATA      : source RAM, 1-cycle read latency
//   WADDR/WDATA/WE   : destination RAM write port
//   MED_DI/MED_DSI   : window data stream to the median core
//   MED_DO/MED_DSO   : median result and its valid pulse
module median_img_ctrl
    import median_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TMO    = TMO_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] RADDR,
    input  logic [width-1:0]  RDATA,
    output logic [ADDR_W-1:0] WADDR,
    output logic [width-1:0]  WDATA,
    output logic              WE,
    output logic [width-1:0]  MED_DI,
    output logic              MED_DSI,
    input  logic [width-1:0]  MED_DO,
    input  logic              MED_DSO
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned TMO_W = (TMO > 0) ? $clog2(TMO + 1) : 1;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [width-1:0]   centre_q, centre_d;
    logic               issue_q, issue_d;
    logic               dsi_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [width-1:0]   wdata_q, wdata_d;

    logic [ROW_W-1:0]   adv_row;
    logic [COL_W-1:0]   adv_col;
    logic [ADDR_W-1:0]  adv_addr;
    logic               adv_border;
    logic               last_pix;

    logic [ADDR_W-1:0]  win_base;
    logic [K_W-1:0]     win_k;
    logic [ADDR_W-1:0]  win_addr_c;

    // Next raster position; the linear address simply increments, row wrap included.
    always_comb begin
        last_pix = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
        if (col_q == COL_W'(IMG_W - 1)) begin
            adv_col = '0;
            adv_row = row_q + ROW_W'(1);
        end else begin
            adv_col = col_q + COL_W'(1);
            adv_row = row_q;
        end
        adv_addr   = addr_q + ADDR_W'(1);
        adv_border = (adv_row == '0) || (adv_row == ROW_W'(IMG_H - 1)) ||
                     (adv_col == '0) || (adv_col == COL_W'(IMG_W - 1));
    end

    // In FETCH the generator looks one beat ahead; in NEXT it yields beat 0 of the next pixel.
    assign win_base = (state_q == ST_FETCH) ? addr_q : adv_addr;
    assign win_k    = (state_q == ST_FETCH) ? (k_q + K_W'(1)) : '0;

    median_win_addr #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_win_addr (
        .base   (win_base),
        .k      (win_k),
        .addr_c (win_addr_c)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            k_q      <= '0;
            tmo_q    <= '0;
            centre_q <= '0;
            issue_q  <= 1'b0;
            dsi_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            k_q      <= k_d;
            tmo_q    <= tmo_d;
            centre_q <= centre_d;
            issue_q  <= issue_d;
            dsi_q    <= issue_q;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        addr_d   = addr_q;
        k_d      = k_q;
        tmo_d    = tmo_q;
        centre_d = centre_q;
        issue_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        we_d     = 1'b0;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                // Pixel (0,0) is always a border pixel.
                if (START && !done_q) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                    raddr_d = '0;
                    state_d = ST_COPY_RD;
                end
            end
            ST_COPY_RD: begin
                state_d = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = RDATA;
                state_d = ST_NEXT;
            end
            ST_FETCH: begin
                // RDATA carries beat k-1 here, so the centre arrives at k = CENTRE_K+1.
                if (k_q == K_W'(CENTRE_K + 1)) begin
                    centre_d = RDATA;
                end
                if (k_q == K_W'(WIN_N - 1)) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_MED;
                end else begin
                    raddr_d = win_addr_c;
                    issue_d = 1'b1;
                    k_d     = k_q + K_W'(1);
                end
            end
            ST_WAIT_MED: begin
                if (MED_DSO) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = MED_DO;
                    state_d = ST_WRITE;
                end else if (tmo_q == TMO_W'(TMO)) begin
                    err_d   = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = centre_q;
                    state_d = ST_WRITE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WRITE: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (last_pix) begin
                    state_d = ST_FINISH;
                end else begin
                    row_d  = adv_row;
                    col_d  = adv_col;
                    addr_d = adv_addr;
                    if (adv_border) begin
                        raddr_d = adv_addr;
                        state_d = ST_COPY_RD;
                    end else begin
                        raddr_d = win_addr_c;
                        issue_d = 1'b1;
                        k_d     = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign RADDR   = raddr_q;
    assign WADDR   = waddr_q;
    assign WDATA   = wdata_q;
    assign WE      = we_q;
    assign MED_DSI = dsi_q;
    assign MED_DI  = RDATA;

endmodule
